// File: rtl/seq_player.sv
// seq_player: steps through LED patterns stored in a synchronous ROM.
// The ROM is addressed by {sequence, step}. Each ROM word carries an
// 8-bit pattern and a last-step flag. slow_clk rising edges advance the step.
module seq_player #(
  parameter int SEQ_W  = 3,
  parameter int STEP_W = 4,
  parameter int LED_W  = 8
) (
  input  logic                    clk_50,
  input  logic                    reset,
  input  logic                    slow_clk,
  input  logic                    run,
  input  logic [SEQ_W-1:0]        seq_num,
  output logic [SEQ_W+STEP_W-1:0] rom_addr,
  input  logic [LED_W:0]          rom_data,
  output logic [LED_W-1:0]        LEDS,
  output logic [STEP_W-1:0]       step,
  output logic                    busy
);

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    LATCH = 2'b01,
    HOLD  = 2'b10
  } state_t;

  state_t           state;
  logic [SEQ_W-1:0] seq_latched;
  logic             last_flag;

  logic sync1;
  logic sync2;
  logic prev;
  logic sync_valid;
  logic armed;
  logic tick;

  // Synchronize slow_clk, keep its previous level, and arm edge detection.
  // armed is set only after the synchronizer has carried a real low level.
  // This stops a slow_clk that is already high at reset release from
  // looking like a fresh rising edge.
  // NOTE: state registers use non-blocking assignments, so every flop
  // samples values from before the edge. Blocking assignments here would
  // collapse the synchronizer chain into a single stage.
  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      prev       <= 1'b0;
      sync_valid <= 1'b0;
      armed      <= 1'b0;
    end else begin
      sync1      <= slow_clk;
      sync2      <= sync1;
      prev       <= sync2;
      sync_valid <= 1'b1;
      if (sync_valid && !sync1) begin
        armed <= 1'b1;
      end
    end
  end

  assign tick = sync2 & ~prev & armed;

  // Player FSM. Priority order: sequence selection, then ROM fetch and
  // latch, then step advance on a tick.
  // A sequence change beats a simultaneous tick and restarts at step 0.
  // A tick that arrives while a fetch is in flight is dropped.
  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      state       <= FETCH;
      step        <= '0;
      seq_latched <= '0;
      last_flag   <= 1'b0;
      LEDS        <= '0;
    end else if (seq_num != seq_latched) begin
      seq_latched <= seq_num;
      step        <= '0;
      state       <= FETCH;
    end else begin
      case (state)
        FETCH: state <= LATCH;
        LATCH: begin
          // The ROM word addressed during FETCH is valid in this cycle.
          LEDS      <= rom_data[LED_W-1:0];
          last_flag <= rom_data[LED_W];
          state     <= HOLD;
        end
        HOLD: begin
          if (tick && run) begin
            if (last_flag || (step == '1)) begin
              step <= '0;
            end else begin
              step <= step + 1'b1;
            end
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  // The ROM address comes only from registers, so seq_num has no
  // combinational path to it.
  assign rom_addr = {seq_latched, step};
  assign busy     = (state == FETCH) || (state == LATCH);

endmodule

// File: tb/tb_seq_player.sv
// Bench for seq_player. It models the synchronous ROM and drives slow_clk
// pulses. Expected {addr, LEDS, step} entries are queued when a tick is
// driven, then popped and compared once the player has settled.
module tb_seq_player;

  localparam int SEQ_W  = 3;
  localparam int STEP_W = 4;
  localparam int LED_W  = 8;

  logic                    clk_50   = 1'b0;
  logic                    reset    = 1'b0;
  logic                    slow_clk = 1'b0;
  logic                    run      = 1'b0;
  logic [SEQ_W-1:0]        seq_num  = '0;
  logic [SEQ_W+STEP_W-1:0] rom_addr;
  logic [LED_W:0]          rom_data = '0;
  logic [LED_W-1:0]        LEDS;
  logic [STEP_W-1:0]       step;
  logic                    busy;

  logic [LED_W:0] rom_mem [0:127];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [SEQ_W+STEP_W-1:0] addr;
    logic [LED_W-1:0]        leds;
    logic [STEP_W-1:0]       step;
  } exp_t;

  exp_t sb[$];

  seq_player #(.SEQ_W(SEQ_W), .STEP_W(STEP_W), .LED_W(LED_W)) dut (
    .clk_50   (clk_50),
    .reset    (reset),
    .slow_clk (slow_clk),
    .run      (run),
    .seq_num  (seq_num),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .LEDS     (LEDS),
    .step     (step),
    .busy     (busy)
  );

  always #10 clk_50 = ~clk_50;

  // Synchronous ROM with one cycle of read latency.
  always @(posedge clk_50) rom_data <= rom_mem[rom_addr];

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1);
  end

  // One slow_clk period: high 8 cycles, then low 6 cycles.
  // This is long enough for the player to fetch and return to HOLD.
  task automatic tick_once();
    @(negedge clk_50);
    slow_clk = 1'b1;
    repeat (8) @(negedge clk_50);
    slow_clk = 1'b0;
    repeat (6) @(negedge clk_50);
  endtask

  task automatic push_exp(input logic [6:0] a, input logic [7:0] l, input logic [3:0] s);
    exp_t e;
    e.addr = a;
    e.leds = l;
    e.step = s;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    reset    = 1'b0;
    seq_num  = 3'd2;
    run      = 1'b1;
    slow_clk = 1'b1;
    repeat (3) @(negedge clk_50);
    checks++;
    if (LEDS !== 8'h00 || step !== 4'd0 || rom_addr !== 7'h00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: LEDS=%h step=%0d addr=%h busy=%b, expected 00/0/00/1",
               LEDS, step, rom_addr, busy);
    end
    // Release reset with slow_clk high. The player must fetch step 0 and
    // must not see a tick.
    push_exp(7'h20, 8'h01, 4'd0);
    reset = 1'b1;
    repeat (10) @(negedge clk_50);
    e = sb.pop_front();
    checks++;
    if (LEDS !== e.leds || rom_addr !== e.addr || step !== e.step || busy !== 1'b0) begin
      errors++;
      $display("FAIL release_high_slow: LEDS=%h addr=%h step=%0d busy=%b, expected %h/%h/%0d/0",
               LEDS, rom_addr, step, busy, e.leds, e.addr, e.step);
    end
    slow_clk = 1'b0;
    repeat (6) @(negedge clk_50);
  endtask

  task automatic test_basic_play();
    logic [7:0] leds_t [3];
    logic [6:0] addr_t [3];
    exp_t e;
    leds_t = '{8'h02, 8'h84, 8'h01};
    addr_t = '{7'h21, 7'h22, 7'h20};
    for (int i = 0; i < 3; i++) begin
      push_exp(addr_t[i], leds_t[i], addr_t[i][3:0]);
      tick_once();
      e = sb.pop_front();
      checks++;
      if (LEDS !== e.leds || rom_addr !== e.addr || step !== e.step || busy !== 1'b0) begin
        errors++;
        $display("FAIL basic_play[%0d]: LEDS=%h addr=%h step=%0d busy=%b, expected %h/%h/%0d/0",
                 i, LEDS, rom_addr, step, busy, e.leds, e.addr, e.step);
      end
    end
  endtask

  task automatic test_latency();
    logic [7:0] old;
    int n;
    n = 0;
    @(negedge clk_50);
    slow_clk = 1'b1;
    old = LEDS;
    for (int i = 1; i <= 20 && n == 0; i++) begin
      @(posedge clk_50);
      @(negedge clk_50);
      if (LEDS !== old) n = i;
    end
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL tick_latency: LEDS changed after %0d cycles (0 = never), expected 5", n);
    end
    checks++;
    if (LEDS !== 8'h02 || step !== 4'd1) begin
      errors++;
      $display("FAIL latency_value: LEDS=%h step=%0d, expected 02/1", LEDS, step);
    end
    slow_clk = 1'b0;
    repeat (6) @(negedge clk_50);
  endtask

  task automatic test_pause();
    exp_t e;
    run = 1'b0;
    for (int i = 0; i < 2; i++) begin
      push_exp(7'h21, 8'h02, 4'd1);
      tick_once();
      e = sb.pop_front();
      checks++;
      if (LEDS !== e.leds || rom_addr !== e.addr || step !== e.step || busy !== 1'b0) begin
        errors++;
        $display("FAIL pause[%0d]: LEDS=%h addr=%h step=%0d busy=%b, expected %h/%h/%0d/0",
                 i, LEDS, rom_addr, step, busy, e.leds, e.addr, e.step);
      end
    end
    run = 1'b1;
    push_exp(7'h22, 8'h84, 4'd2);
    tick_once();
    e = sb.pop_front();
    checks++;
    if (LEDS !== e.leds || rom_addr !== e.addr || step !== e.step || busy !== 1'b0) begin
      errors++;
      $display("FAIL resume: LEDS=%h addr=%h step=%0d busy=%b, expected %h/%h/%0d/0",
               LEDS, rom_addr, step, busy, e.leds, e.addr, e.step);
    end
  endtask

  task automatic test_seq_change_with_tick();
    exp_t e;
    @(negedge clk_50);
    slow_clk = 1'b1;
    // The tick is high in the cycle after the second rising edge. Change
    // seq_num so the DUT sees both changes on the same edge.
    @(negedge clk_50);
    @(negedge clk_50);
    seq_num = 3'd5;
    push_exp(7'h50, 8'hA5, 4'd0);
    @(negedge clk_50);
    checks++;
    if (step !== 4'd0 || rom_addr !== 7'h50 || LEDS !== 8'h84 || busy !== 1'b1) begin
      errors++;
      $display("FAIL seq_change_fetch: step=%0d addr=%h LEDS=%h busy=%b, expected 0/50/84/1",
               step, rom_addr, LEDS, busy);
    end
    @(negedge clk_50);
    checks++;
    if (LEDS !== 8'h84) begin
      errors++;
      $display("FAIL seq_change_hold_old: LEDS=%h, expected 84", LEDS);
    end
    @(negedge clk_50);
    e = sb.pop_front();
    checks++;
    if (LEDS !== e.leds || rom_addr !== e.addr || step !== e.step || busy !== 1'b0) begin
      errors++;
      $display("FAIL seq_change_latched: LEDS=%h addr=%h step=%0d busy=%b, expected %h/%h/%0d/0",
               LEDS, rom_addr, step, busy, e.leds, e.addr, e.step);
    end
    slow_clk = 1'b0;
    repeat (6) @(negedge clk_50);
  endtask

  task automatic test_wrap();
    exp_t e;
    logic [3:0] s;
    seq_num = 3'd7;
    repeat (6) @(negedge clk_50);
    checks++;
    if (LEDS !== 8'h10 || step !== 4'd0 || rom_addr !== 7'h70) begin
      errors++;
      $display("FAIL wrap_start: LEDS=%h step=%0d addr=%h, expected 10/0/70", LEDS, step, rom_addr);
    end
    for (int i = 0; i < 16; i++) begin
      s = 4'((i + 1) % 16);
      push_exp({3'd7, s}, 8'h10 + {4'h0, s}, s);
      tick_once();
      e = sb.pop_front();
      checks++;
      if (LEDS !== e.leds || rom_addr !== e.addr || step !== e.step || busy !== 1'b0) begin
        errors++;
        $display("FAIL wrap[%0d]: LEDS=%h addr=%h step=%0d busy=%b, expected %h/%h/%0d/0",
                 i, LEDS, rom_addr, step, busy, e.leds, e.addr, e.step);
      end
    end
  endtask

  task automatic test_reset_mid_latch();
    int found;
    found = 0;
    @(negedge clk_50);
    slow_clk = 1'b1;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk_50);
      if (busy === 1'b1) found = 1;
    end
    checks++;
    if (found == 0) begin
      errors++;
      $display("FAIL mid_latch_busy: busy never rose within 20 cycles, expected 1");
    end
    @(negedge clk_50);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (LEDS !== 8'h00 || step !== 4'd0 || rom_addr !== 7'h00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: LEDS=%h step=%0d addr=%h busy=%b, expected 00/0/00/1",
               LEDS, step, rom_addr, busy);
    end
    slow_clk = 1'b0;
    seq_num  = 3'd3;
    repeat (3) @(negedge clk_50);
    checks++;
    if (LEDS !== 8'h00) begin
      errors++;
      $display("FAIL reset_no_update: LEDS=%h, expected 00", LEDS);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk_50);
    checks++;
    if (rom_addr !== 7'h30) begin
      errors++;
      $display("FAIL release_addr: addr=%h, expected 30", rom_addr);
    end
    repeat (6) @(negedge clk_50);
    checks++;
    if (LEDS !== 8'h33 || step !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL release_play: LEDS=%h step=%0d busy=%b, expected 33/0/0", LEDS, step, busy);
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom_mem[i] = '0;
    rom_mem[7'h20] = 9'h001;
    rom_mem[7'h21] = 9'h002;
    rom_mem[7'h22] = 9'h184;
    rom_mem[7'h30] = 9'h133;
    rom_mem[7'h50] = 9'h0A5;
    rom_mem[7'h51] = 9'h15A;
    for (int i = 0; i < 16; i++) rom_mem[7'h70 + i] = 9'(8'h10 + i);

    test_reset();
    test_basic_play();
    test_latency();
    test_pause();
    test_seq_change_with_tick();
    test_wrap();
    test_reset_mid_latch();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
